mips_multicycle_core: RTL and testbench
=======================================

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the byte-address width of the PC, imem_addr and dmem_addr.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter HALT_ON_ILLEGAL, default 1: 1 SHALL halt on an undecoded opcode/funct; 0 SHALL treat it as a no-op.
REQ-004 The ports SHALL be as follows; one clock; reset is asynchronous and active-low.
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  imem_req  out  1  instruction fetch request
  imem_addr  out  ADDR_W  fetch byte address (= PC)
  imem_rdata  in  32  big-endian instruction word
  imem_ready  in  1  fetch complete, imem_rdata valid this cycle
  dmem_req  out  1  data access request
  dmem_we  out  1  1 = store, 0 = load
  dmem_addr  out  ADDR_W  data byte address (rs + sign-extended imm)
  dmem_wdata  out  32  store data (rt)
  dmem_rdata  in  32  load data, big-endian
  dmem_ready  in  1  data access complete
  halt  out  1  core stopped
  pc_out  out  ADDR_W  current PC

Function
REQ-005 The core SHALL be a multicycle FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-006 FETCH SHALL hold imem_req=1 with imem_addr stable until imem_ready=1 at a rising edge, then latch the IR and go to DECODE.
REQ-007 MEM SHALL hold dmem_req=1 and stable dmem_we/addr/wdata until dmem_ready=1 at a rising edge; load data SHALL be latched on that edge.
REQ-008 imem_ready/dmem_ready SHALL be ignored while the matching req=0; a req SHALL drop in the cycle after acceptance.
REQ-009 Supported: R-type add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08; lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08; j 0x02, jal 0x03.
REQ-010 With zero wait states, cycles per instruction SHALL be: R-type/addi 4 (FETCH,DECODE,EXEC,WB); lw 5; sw 4 (FETCH,DECODE,EXEC,MEM); beq/bne/j/jal/jr 3 (FETCH,DECODE,EXEC). Each wait cycle adds exactly one.
REQ-011 Arithmetic SHALL wrap modulo 2^32 with no overflow trap; slt SHALL compare signed.
REQ-012 Register $0 SHALL always read 0; writes to it SHALL be discarded.
REQ-013 The PC SHALL update only in EXEC (branch/jump) or at the last state of the instruction (PC+4), never mid-instruction.
REQ-014 Branch target SHALL be PC+4+(sext(imm)<<2); j/jal target SHALL be {(PC+4)[ADDR_W-1:28], instr[25:0], 2'b00}; jr target SHALL be rs.
REQ-015 jal SHALL write PC+4 to $31 in EXEC; jr $31 immediately after SHALL observe it.
REQ-016 A lw/sw with dmem_addr[1:0]!=0 SHALL enter HALT without asserting dmem_req.
REQ-017 An illegal instruction with HALT_ON_ILLEGAL=1 SHALL enter HALT from DECODE; with 0 it SHALL advance PC by 4.
REQ-018 In HALT, halt SHALL be 1, both reqs 0, and PC and registers frozen until reset.
REQ-019 PC SHALL wrap modulo 2^ADDR_W.

Reset
REQ-020 rst_n=0 SHALL immediately force FETCH, PC=RESET_PC, all 32 registers 0, imem_req=0, dmem_req=0, dmem_we=0, halt=0; address/data outputs 0.
REQ-021 Reset asserted mid-access SHALL abandon it (req low asynchronously, no register or PC update); the first FETCH SHALL issue at the first rising edge after rst_n=1.

Verification
REQ-022 The bench SHALL cover these scenarios:
  addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 with zero waits -> $3=2 after 12 cycles, pc_out=0x0C.
  sw $3,4($0) then lw $4,4($0), dmem_ready delayed 2 cycles each -> stored word 0x00000002, $4=2, lw takes 7 cycles.
  beq $0,$0,-1 at 0x10 -> PC returns to 0x10 every 3 cycles; bne $0,$0 at 0x10 -> PC=0x14.
  jal 0x40 at 0x20, jr $31 at 0x40 -> $31=0x24, PC=0x24 after 6 cycles.
  lw $5,2($0) -> halt=1, dmem_req never asserted; opcode 0x3F with HALT_ON_ILLEGAL=1 -> halt=1, PC frozen.
  rst_n low during MEM wait of a sw -> dmem_req low same cycle, PC=RESET_PC, no store completed.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-subset core
// (FETCH, DECODE, EXEC, MEM, WB, HALT).
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   imem_req/addr      instruction fetch request and byte address (= PC)
//   imem_rdata/ready   fetched big-endian word, valid when ready=1
//   dmem_req/we/addr   data access request, 1=store, byte address
//   dmem_wdata         store data (rt)
//   dmem_rdata/ready   load data, access complete
//   halt               core stopped until reset
//   pc_out             current PC
module mips_multicycle_core #(
   parameter int unsigned       ADDR_W          = 32,
   parameter logic [ADDR_W-1:0] RESET_PC        = '0,
   parameter bit                HALT_ON_ILLEGAL = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ready,
   output logic              halt,
   output logic [ADDR_W-1:0] pc_out
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
   logic [31:0]       ir_q, ir_d, res_q, res_d, wdata_q, wdata_d;
   logic              started_q;
   logic [31:0]       regs_q [32];

   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [31:0]       rf_wdata;

   // Instruction fields
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   assign op    = ir_q[31:26];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign shamt = ir_q[10:6];
   assign funct = ir_q[5:0];
   assign imm   = ir_q[15:0];

   // Decode; R-type with a nonzero shamt field is treated as undecoded
   logic is_r, r_alu, is_jr, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_jal, legal;
   assign is_r    = (op == 6'h00) && (shamt == 5'd0);
   assign r_alu   = is_r && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
   assign is_jr   = is_r && (funct == 6'h08);
   assign is_lw   = (op == 6'h23);
   assign is_sw   = (op == 6'h2B);
   assign is_beq  = (op == 6'h04);
   assign is_bne  = (op == 6'h05);
   assign is_addi = (op == 6'h08);
   assign is_j    = (op == 6'h02);
   assign is_jal  = (op == 6'h03);
   assign legal   = r_alu | is_jr | is_lw | is_sw | is_beq | is_bne | is_addi | is_j | is_jal;

   // Operands and datapath
   logic [31:0]       rs_val, rt_val, sext_imm, alu_b, alu_y, mem_sum;
   logic [ADDR_W-1:0] pc4, br_target, j_target;
   assign rs_val    = (rs == 5'd0) ? '0 : regs_q[rs];
   assign rt_val    = (rt == 5'd0) ? '0 : regs_q[rt];
   assign sext_imm  = {{16{imm[15]}}, imm};
   assign alu_b     = is_addi ? sext_imm : rt_val;
   assign mem_sum   = rs_val + sext_imm;
   assign pc4       = pc_q + ADDR_W'(4);
   assign br_target = pc4 + ADDR_W'($signed({sext_imm[29:0], 2'b00}));
   assign j_target  = (pc4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({ir_q[25:0], 2'b00});

   always_comb begin
      alu_y = rs_val + alu_b;
      if (r_alu) begin
         case (funct)
            6'h22:   alu_y = rs_val - rt_val;
            6'h24:   alu_y = rs_val & rt_val;
            6'h25:   alu_y = rs_val | rt_val;
            6'h2A:   alu_y = {31'd0, $signed(rs_val) < $signed(rt_val)};
            default: alu_y = rs_val + rt_val;
         endcase
      end
   end

   // Next-state logic; PC only moves in EXEC (control flow) or the final state
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      res_d    = res_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      case (state_q)
         FETCH: begin
            if (imem_req && imem_ready) begin
               ir_d    = imem_rdata;
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = (!legal && HALT_ON_ILLEGAL) ? HALT : EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            if (r_alu || is_addi) begin
               res_d   = alu_y;
               state_d = WB;
            end else if (is_lw || is_sw) begin
               if (mem_sum[1:0] != 2'b00) begin
                  state_d = HALT;
               end else begin
                  addr_d  = ADDR_W'(mem_sum);
                  wdata_d = rt_val;
                  state_d = MEM;
               end
            end else if (is_beq) begin
               pc_d = (rs_val == rt_val) ? br_target : pc4;
            end else if (is_bne) begin
               pc_d = (rs_val != rt_val) ? br_target : pc4;
            end else if (is_j) begin
               pc_d = j_target;
            end else if (is_jal) begin
               pc_d     = j_target;
               rf_we    = 1'b1;
               rf_waddr = 5'd31;
               rf_wdata = 32'(pc4);
            end else if (is_jr) begin
               pc_d = ADDR_W'(rs_val);
            end else begin
               pc_d = pc4;
            end
         end
         MEM: begin
            if (dmem_ready) begin
               if (is_lw) begin
                  res_d   = dmem_rdata;
                  state_d = WB;
               end else begin
                  pc_d    = pc4;
                  state_d = FETCH;
               end
            end
         end
         WB: begin
            rf_we    = 1'b1;
            rf_waddr = r_alu ? rd : rt;
            rf_wdata = res_q;
            pc_d     = pc4;
            state_d  = FETCH;
         end
         default: state_d = HALT;
      endcase
   end

   // started_q holds off the first fetch until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         res_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         res_q     <= res_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         started_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (rf_we && (rf_waddr != 5'd0)) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

   assign imem_req   = (state_q == FETCH) && started_q;
   assign imem_addr  = imem_req ? pc_q : '0;
   assign dmem_req   = (state_q == MEM);
   assign dmem_we    = dmem_req && is_sw;
   assign dmem_addr  = dmem_req ? addr_q : '0;
   assign dmem_wdata = dmem_we ? wdata_q : '0;
   assign halt       = (state_q == HALT);
   assign pc_out     = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: self-checking bench for mips_multicycle_core.
// Memory models answer fetch/data requests with programmable wait states;
// expected data accesses are queued and compared as the core issues them.
module tb_mips_multicycle_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, dmem_req, dmem_we, halt;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata, pc_out;
   logic [31:0] imem_rdata = '0, dmem_rdata = '0;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0;

   always #5 clk = ~clk;

   mips_multicycle_core #(
      .ADDR_W(32),
      .RESET_PC(32'h0),
      .HALT_ON_ILLEGAL(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .halt(halt), .pc_out(pc_out)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Memories and responders
   logic [31:0] imem [0:255];
   logic [31:0] dmem [0:255];
   int unsigned imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
   bit          dmem_seen = 1'b0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;
   acc_t exp_q[$];

   task automatic push_acc(input logic we, input logic [31:0] addr, input logic [31:0] data);
      acc_t a;
      a.we = we; a.addr = addr; a.data = data;
      exp_q.push_back(a);
   endtask

   task automatic serve_dmem();
      acc_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL dmem_unexpected actual=we%0d@0x%08h expected=no access", dmem_we, dmem_addr);
      end else begin
         e = exp_q.pop_front();
         check("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
         check("dmem_addr", dmem_addr, e.addr);
         if (e.we) begin
            check("dmem_wdata", dmem_wdata, e.data);
            dmem[dmem_addr[9:2]] = dmem_wdata;
         end
      end
      dmem_rdata = dmem[dmem_addr[9:2]];
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (imem_req) begin
            if (icnt >= imem_wait) begin
               imem_ready = 1'b1;
               imem_rdata = imem[imem_addr[9:2]];
            end else begin
               imem_ready = 1'b0;
               icnt++;
            end
         end else begin
            imem_ready = 1'b0;
            icnt = 0;
         end
         if (dmem_req) begin
            dmem_seen = 1'b1;
            if (dcnt >= dmem_wait) begin
               serve_dmem();
               dmem_ready = 1'b1;
            end else begin
               dmem_ready = 1'b0;
               dcnt++;
            end
         end else begin
            dmem_ready = 1'b0;
            dcnt = 0;
         end
      end
   end

   // Encoders
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'd0, funct};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] widx);
      return {op, widx};
   endfunction

   // Sequencing helpers
   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         imem[i] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);  // park: beq $0,$0,-1
         dmem[i] = '0;
      end
      exp_q.delete();
      dmem_seen = 1'b0;
      imem_wait = 0;
      dmem_wait = 0;
   endtask

   // Returns at the first rising edge after release (the edge that issues FETCH)
   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("imem_req_before_first_edge", {31'd0, imem_req}, 32'd0);
      @(posedge clk);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

   typedef struct {
      string       name;
      logic [5:0]  funct;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"add_wrap",    6'h20, 5'd3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
      vecs[1] = '{"add_carry",   6'h20, 5'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vecs[2] = '{"sub_neg",     6'h22, 5'd3, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[3] = '{"sub_wrap",    6'h22, 5'd3, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
      vecs[4] = '{"and",         6'h24, 5'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
      vecs[5] = '{"or",          6'h25, 5'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
      vecs[6] = '{"slt_neg_pos", 6'h2A, 5'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      vecs[7] = '{"slt_pos_neg", 6'h2A, 5'd3, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[8] = '{"slt_min_max", 6'h2A, 5'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
      vecs[9] = '{"write_r0",    6'h20, 5'd0, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};

      // Reset state
      hold_reset();
      clear_mem();
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      check("rst_halt", {31'd0, halt}, 32'd0);
      check("rst_pc", pc_out, 32'h0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_dmem_wdata", dmem_wdata, 32'h0);

      // ALU table: lw $1; lw $2; op rd,$1,$2; sw rd,0x108
      for (int v = 0; v < 10; v++) begin
         hold_reset();
         clear_mem();
         imem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'h0100);
         imem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h0104);
         imem[2] = enc_r(5'd1, 5'd2, vecs[v].rd, vecs[v].funct);
         imem[3] = enc_i(6'h2B, 5'd0, vecs[v].rd, 16'h0108);
         dmem[8'h40] = vecs[v].a;
         dmem[8'h41] = vecs[v].b;
         push_acc(1'b0, 32'h100, '0);
         push_acc(1'b0, 32'h104, '0);
         push_acc(1'b1, 32'h108, vecs[v].exp);
         release_reset();
         wait_drain(80);
         check({"result_", vecs[v].name}, dmem[8'h42], vecs[v].exp);
      end

      // addi/addi/add, then sw/lw with two data wait states each
      hold_reset();
      clear_mem();
      dmem_wait = 2;
      imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0005);
      imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
      imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0004);
      imem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'h0004);
      imem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0008);
      push_acc(1'b1, 32'h4, 32'h2);
      push_acc(1'b0, 32'h4, '0);
      push_acc(1'b1, 32'h8, 32'h2);
      release_reset();
      cyc(12); check("pc_after_3_alu", pc_out, 32'h0C);
      cyc(6);  check("pc_after_sw_waits", pc_out, 32'h10);
      cyc(3);  check("pc_frozen_mid_lw", pc_out, 32'h10);
      cyc(4);  check("pc_after_lw_7cyc", pc_out, 32'h14);
      cyc(6);  check("pc_after_sw2", pc_out, 32'h18);
      check("stored_word", dmem[1], 32'h2);
      check("lw_result_stored", dmem[2], 32'h2);
      check("seq_queue_empty", 32'(exp_q.size()), 32'd0);

      // beq $0,$0,-1 at 0x10 loops every 3 cycles
      hold_reset();
      clear_mem();
      imem[0] = enc_j(6'h02, 26'h4);
      imem[4] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
      release_reset();
      cyc(3);
      check("j_to_0x10", pc_out, 32'h10);
      check("loop_fetch0", {31'd0, imem_req}, 32'd1);
      for (int k = 1; k <= 6; k++) begin
         cyc(1);
         check("beq_loop_pc", pc_out, 32'h10);
         check("beq_loop_fetch", {31'd0, imem_req}, (k % 3 == 0) ? 32'd1 : 32'd0);
      end

      // bne $0,$0 falls through
      hold_reset();
      clear_mem();
      imem[0] = enc_j(6'h02, 26'h4);
      imem[4] = enc_i(6'h05, 5'd0, 5'd0, 16'h0005);
      release_reset();
      cyc(6); check("bne_not_taken", pc_out, 32'h14);

      // jal 0x40 at 0x20, jr $31 at 0x40, then sw $31
      hold_reset();
      clear_mem();
      imem[0]     = enc_j(6'h02, 26'h8);
      imem[8]     = enc_j(6'h03, 26'h10);
      imem[16]    = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
      imem[9]     = enc_i(6'h2B, 5'd0, 5'd31, 16'h000C);
      push_acc(1'b1, 32'hC, 32'h24);
      release_reset();
      cyc(3); check("j_to_0x20", pc_out, 32'h20);
      cyc(3); check("jal_target", pc_out, 32'h40);
      cyc(3); check("jr_ra", pc_out, 32'h24);
      wait_drain(20);

      // misaligned lw $5,2($0)
      hold_reset();
      clear_mem();
      imem[0] = enc_i(6'h23, 5'd0, 5'd5, 16'h0002);
      release_reset();
      cyc(2);  check("misalign_not_yet_halt", {31'd0, halt}, 32'd0);
      cyc(1);  check("misalign_halt", {31'd0, halt}, 32'd1);
      cyc(10);
      check("misalign_halt_held", {31'd0, halt}, 32'd1);
      check("misalign_pc_frozen", pc_out, 32'h0);
      check("misalign_no_fetch", {31'd0, imem_req}, 32'd0);
      check("misalign_no_dmem_req", {31'd0, dmem_seen}, 32'd0);

      // illegal opcode 0x3F
      hold_reset();
      clear_mem();
      imem[0] = 32'hFC00_0000;
      release_reset();
      cyc(1);  check("illegal_decode_not_halt", {31'd0, halt}, 32'd0);
      cyc(1);  check("illegal_halt", {31'd0, halt}, 32'd1);
      cyc(10);
      check("illegal_pc_frozen", pc_out, 32'h0);
      check("illegal_no_fetch", {31'd0, imem_req}, 32'd0);

      // reset during the MEM wait of a sw
      hold_reset();
      clear_mem();
      dmem_wait = 10;
      imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0007);
      imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0020);
      release_reset();
      cyc(7);
      check("mem_req_up", {31'd0, dmem_req}, 32'd1);
      check("mem_we_up", {31'd0, dmem_we}, 32'd1);
      check("mem_addr", dmem_addr, 32'h20);
      check("mem_wdata", dmem_wdata, 32'h7);
      cyc(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("async_rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      check("async_rst_pc", pc_out, 32'h0);
      repeat (3) @(negedge clk);
      check("no_store_completed", dmem[8], 32'h0);
      clear_mem();
      release_reset();
      #1;
      check("first_fetch_req", {31'd0, imem_req}, 32'd1);
      check("first_fetch_addr", imem_addr, 32'h0);
      cyc(6); check("post_reset_pc", pc_out, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
